nbin_stream_unpacker: RTL and testbench
=======================================

Name: nbin_stream_unpacker

Overview:
- Reader end of the reduced-precision NBout packing path.
- Consumes a stream of 16-bit memory words holding tightly bit-packed N-bit values (N = 1..16, LSB-first, values may straddle word boundaries).
- Emits one full-width 16-bit value per handshake, zero- or sign-extended, ready for NBin.
- Sits between the memory read port and the NBin write port.

Parameters:
BIT_WIDTH, 16, width of memory words and of output values
PREC_BITS, 5, width of precision field (encodes 0..16)
CNT_BITS, 16, width of value-count field

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
i_start  input  1  one-cycle pulse; latches i_n, i_signed, i_count; clears bit buffer; enters RUN
i_n  input  PREC_BITS  value precision; 0 treated as 16; values >16 treated as 16
i_signed  input  1  1 = sign-extend from bit N-1, 0 = zero-extend
i_count  input  CNT_BITS  number of values to emit this transfer
i_word  input  BIT_WIDTH  packed memory word
i_word_valid  input  1  i_word is valid
o_word_ready  output  1  block accepts i_word this cycle
o_val  output  BIT_WIDTH  unpacked, extended value
o_val_valid  output  1  o_val is valid
i_val_ready  input  1  downstream accepts o_val
o_busy  output  1  high while in RUN
o_done  output  1  one-cycle pulse after last value handshake

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset. One clock domain only.
- On reset, all of the following are 0: o_word_ready, o_val_valid, o_busy, o_done, o_val, the 32-bit bit buffer, occupancy (0..32), remaining count. State is IDLE.
- Reset mid-transfer aborts immediately. Buffered bits are discarded.
- States:
  - IDLE: waits for i_start.
  - RUN: transfer in progress.
  - DONE: one cycle, o_done=1; next state is IDLE.
- IDLE -> RUN on i_start with i_count != 0.
- i_start with i_count == 0 -> DONE next cycle; no words accepted, no values emitted.
- i_start during RUN restarts the transfer: buffer and occupancy cleared, new config latched. Any word or value handshake in that same cycle is ignored.
- i_start during DONE is ignored.
- o_word_ready = (state == RUN) && (occupancy <= 16).
  - This is a combinational function of registered state only.
  - It must not depend on i_word_valid or i_val_ready.
- Word handshake (ready && valid):
  - i_word is written into the buffer at bit position (occupancy - popped bits).
  - Occupancy increases by 16.
- o_val_valid = (state == RUN) && (occupancy >= N) && (remaining > 0).
- o_val = extend(buffer[N-1:0]). Bits above N-1 are masked before extension.
- Value handshake (valid && ready):
  - Buffer shifts right by N.
  - Occupancy decreases by N.
  - Remaining decrements.
- Simultaneous word and value handshake in one cycle:
  - next buffer = (buffer >> N) | (i_word << (occupancy - N)).
  - next occupancy = occupancy - N + 16.
  - Never exceeds 32.
- Latency: a word accepted at edge t makes o_val_valid high in cycle t+1 if occupancy then >= N. Zero bubble between back-to-back values while bits are available.
- Holding rule: o_val and o_val_valid stay stable while i_val_ready is low.
- End of transfer: when remaining reaches 0 on the last value handshake:
  - Next state is DONE.
  - o_word_ready and o_val_valid drop the same cycle.
  - Leftover buffered bits (tail padding) are discarded.
- Words offered when o_word_ready=0 are not consumed. The source must hold them.

Test Plan:
- N=4 unsigned, count=4, word 0x4321 -> values 0x0001, 0x0002, 0x0003, 0x0004 on consecutive cycles with i_val_ready=1; o_done pulses once; exactly 1 word accepted.
- N=12 signed, count=4, words 0x1ABC, 0x3F2E, 0x0005 -> values 0xFABC, 0x02E1, 0x053F, 0x0000; exactly 3 words accepted.
- N=0 (16-bit mode) unsigned, count=3, words 0x8001, 0x7FFF, 0x1234 -> identical values emitted; signed mode gives the same 16-bit results.
- Backpressure: N=5 signed, i_val_ready toggled randomly, 16 values of 0x1F packed into 5 words -> all 16 values read 0xFFFF; o_val stable while stalled; o_word_ready never high with occupancy > 16.
- i_count=0 start -> o_done high exactly 1 cycle later; o_word_ready never asserted.
- Reset asserted after 2 of 4 values, then new start with N=8, count=2, word 0xBEEF -> values 0x00EF, 0x00BE; no stale bits from the aborted transfer.

Source files
------------

// File: rtl/nbin_stream_unpacker_if.sv
// nbin_stream_unpacker_if: config, packed-word and unpacked-value streams of the NBin unpacker
// Ports: i_start/i_n/i_signed/i_count transfer config; i_word/i_word_valid/o_word_ready packed input;
// o_val/o_val_valid/i_val_ready extended output; o_busy/o_done status. slave = unpacker, master = environment.
interface nbin_stream_unpacker_if #(
  parameter int BIT_WIDTH = 16,
  parameter int PREC_BITS = 5,
  parameter int CNT_BITS = 16
);
  logic i_start;
  logic [PREC_BITS-1:0] i_n;
  logic i_signed;
  logic [CNT_BITS-1:0] i_count;
  logic [BIT_WIDTH-1:0] i_word;
  logic i_word_valid;
  logic o_word_ready;
  logic [BIT_WIDTH-1:0] o_val;
  logic o_val_valid;
  logic i_val_ready;
  logic o_busy;
  logic o_done;
  modport slave (
    input i_start, i_n, i_signed, i_count, i_word, i_word_valid, i_val_ready,
    output o_word_ready, o_val, o_val_valid, o_busy, o_done
  );
  modport master (
    output i_start, i_n, i_signed, i_count, i_word, i_word_valid, i_val_ready,
    input o_word_ready, o_val, o_val_valid, o_busy, o_done
  );
endinterface

// File: rtl/nbin_stream_unpacker.sv
// nbin_stream_unpacker: unpacks LSB-first N-bit values from 16-bit words into extended 16-bit values
// Ports: clk, reset (sync active-high), bus (slave modport of nbin_stream_unpacker_if).
module nbin_stream_unpacker #(
  parameter int BIT_WIDTH = 16,
  parameter int PREC_BITS = 5,
  parameter int CNT_BITS = 16
) (
  input logic clk,
  input logic reset,
  nbin_stream_unpacker_if.slave bus
);
  localparam int BW2 = 2 * BIT_WIDTH;
  localparam int OW = $clog2(BW2 + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [BW2-1:0] bits, nxt_bits, mask_full;
  logic [OW-1:0] occ, n_q, pop, n_eff;
  logic [CNT_BITS-1:0] rem;
  logic sgn_q, word_hs, val_hs, sign;
  logic [BIT_WIDTH-1:0] mask, raw;
  assign bus.o_busy = state == RUN;
  assign bus.o_done = state == DONE;
  assign bus.o_word_ready = state == RUN && occ <= OW'(BIT_WIDTH);
  assign bus.o_val_valid = state == RUN && occ >= n_q && rem != '0;
  assign word_hs = bus.o_word_ready && bus.i_word_valid;
  assign val_hs = bus.o_val_valid && bus.i_val_ready;
  assign n_eff = (bus.i_n == '0 || OW'(bus.i_n) > OW'(BIT_WIDTH)) ? OW'(BIT_WIDTH) : OW'(bus.i_n);
  always_comb begin
    mask_full = (BW2'(1) << n_q) - BW2'(1);
    mask = mask_full[BIT_WIDTH-1:0];
    raw = bits[BIT_WIDTH-1:0] & mask;
    // mask ^ (mask >> 1) isolates bit N-1 without a variable index
    sign = sgn_q && |(raw & (mask ^ (mask >> 1)));
    bus.o_val = sign ? raw | ~mask : raw;
    pop = val_hs ? n_q : '0;
    // new word lands just above the bits that survive this cycle's pop
    nxt_bits = (bits >> pop) | (word_hs ? BW2'(bus.i_word) << (occ - pop) : '0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bits <= '0;
      occ <= '0;
      rem <= '0;
      n_q <= '0;
      sgn_q <= 1'b0;
    end else if (bus.i_start && state != DONE) begin
      state <= bus.i_count == '0 ? DONE : RUN;
      bits <= '0;
      occ <= '0;
      rem <= bus.i_count;
      n_q <= n_eff;
      sgn_q <= bus.i_signed;
    end else if (state == DONE) begin
      state <= IDLE;
    end else if (state == RUN && val_hs && rem == CNT_BITS'(1)) begin
      state <= DONE;
      bits <= '0;
      occ <= '0;
      rem <= '0;
    end else if (state == RUN) begin
      bits <= nxt_bits;
      occ <= occ - pop + (word_hs ? OW'(BIT_WIDTH) : '0);
      rem <= rem - (val_hs ? CNT_BITS'(1) : '0);
    end
  end
endmodule

// File: tb/tb_nbin_stream_unpacker.sv
// tb_nbin_stream_unpacker: table vectors, hand sequences and random transfers against a bit-stream model
module tb_nbin_stream_unpacker;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  nbin_stream_unpacker_if bus ();
  nbin_stream_unpacker dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    int n;
    bit sgn;
    int cnt;
    int nw;
    logic [15:0] w [3];
    logic [15:0] v [4];
  } vec_t;
  vec_t tbl [5];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  function automatic logic [15:0] ref_val(input logic [15:0] w[$], input int neff, input bit sgn, input int k);
    logic [15:0] v = '0;
    logic [15:0] t;
    for (int b = 0; b < neff; b++) begin
      t = w[(k * neff + b) / 16];
      v[b] = t[(k * neff + b) % 16];
    end
    if (sgn && v[neff-1]) for (int b = neff; b < 16; b++) v[b] = 1'b1;
    return v;
  endfunction
  task automatic run(input int n, input bit sgn, input int cnt, input logic [15:0] w[$],
                     input logic [15:0] e[$], input bit rnd, input int abort_at);
    int wi = 0;
    int vi = 0;
    int nw = w.size();
    bit done_seen = 0;
    bit prev_stall = 0;
    logic [15:0] prev_val = '0;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_n = 5'(n);
    bus.i_signed = sgn;
    bus.i_count = 16'(cnt);
    bus.i_word_valid = 1'b0;
    bus.i_val_ready = 1'b0;
    @(negedge clk);
    bus.i_start = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
      bus.i_word_valid = wi < nw;
      bus.i_word = '0;
      if (wi < nw) bus.i_word = w[wi];
      bus.i_val_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (cyc == 0) chk("busy", 32'(bus.o_busy), 1);
      if (bus.o_done) done_seen = 1;
      else begin
        if (prev_stall) begin
          chk("hold_valid", 32'(bus.o_val_valid), 1);
          chk("hold_val", 32'(bus.o_val), 32'(prev_val));
        end
        if (bus.o_word_ready && bus.i_word_valid) wi++;
        if (bus.o_val_valid && bus.i_val_ready) begin
          if (vi < cnt) chk($sformatf("val%0d", vi), 32'(bus.o_val), 32'(e[vi]));
          else chk("val_overrun", vi, cnt - 1);
          vi++;
        end
        prev_stall = bus.o_val_valid && !bus.i_val_ready;
        prev_val = bus.o_val;
      end
      if (abort_at > 0 && vi == abort_at) return;
      @(negedge clk);
    end
    bus.i_word_valid = 1'b0;
    bus.i_val_ready = 1'b0;
    chk("done_seen", 32'(done_seen), 1);
    chk("val_count", vi, cnt);
    chk("word_count", wi, nw);
    @(negedge clk);
    #1;
    chk("done_pulse", 32'(bus.o_done), 0);
  endtask
  task automatic chk_idle(input string name);
    chk({name, "_ready"}, 32'(bus.o_word_ready), 0);
    chk({name, "_valid"}, 32'(bus.o_val_valid), 0);
    chk({name, "_busy"}, 32'(bus.o_busy), 0);
    chk({name, "_done"}, 32'(bus.o_done), 0);
    chk({name, "_val"}, 32'(bus.o_val), 0);
  endtask
  initial begin
    logic [15:0] wq[$];
    logic [15:0] eq[$];
    tbl[0] = '{4, 1'b0, 4, 1, '{16'h4321, 16'h0, 16'h0}, '{16'h0001, 16'h0002, 16'h0003, 16'h0004}};
    tbl[1] = '{12, 1'b1, 4, 3, '{16'h1ABC, 16'h3F2E, 16'h0005}, '{16'hFABC, 16'h02E1, 16'h053F, 16'h0000}};
    tbl[2] = '{0, 1'b0, 3, 3, '{16'h8001, 16'h7FFF, 16'h1234}, '{16'h8001, 16'h7FFF, 16'h1234, 16'h0}};
    tbl[3] = '{0, 1'b1, 3, 3, '{16'h8001, 16'h7FFF, 16'h1234}, '{16'h8001, 16'h7FFF, 16'h1234, 16'h0}};
    tbl[4] = '{20, 1'b1, 3, 3, '{16'h8001, 16'h7FFF, 16'h1234}, '{16'h8001, 16'h7FFF, 16'h1234, 16'h0}};
    bus.i_start = 1'b0;
    bus.i_n = '0;
    bus.i_signed = 1'b0;
    bus.i_count = '0;
    bus.i_word = '0;
    bus.i_word_valid = 1'b0;
    bus.i_val_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_idle("reset");
    reset = 1'b0;
    foreach (tbl[i]) begin
      wq = {};
      eq = {};
      for (int j = 0; j < tbl[i].nw; j++) wq.push_back(tbl[i].w[j]);
      for (int j = 0; j < tbl[i].cnt; j++) eq.push_back(tbl[i].v[j]);
      run(tbl[i].n, tbl[i].sgn, tbl[i].cnt, wq, eq, 1'b0, 0);
    end
    wq = {};
    eq = {};
    for (int j = 0; j < 5; j++) wq.push_back(16'hFFFF);
    for (int j = 0; j < 16; j++) eq.push_back(16'hFFFF);
    run(5, 1'b1, 16, wq, eq, 1'b1, 0);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_n = 5'd4;
    bus.i_count = '0;
    bus.i_word = 16'hAAAA;
    bus.i_word_valid = 1'b1;
    #1;
    chk("zc_ready_start", 32'(bus.o_word_ready), 0);
    @(negedge clk);
    bus.i_start = 1'b0;
    #1;
    chk("zc_done", 32'(bus.o_done), 1);
    chk("zc_ready", 32'(bus.o_word_ready), 0);
    @(negedge clk);
    #1;
    chk("zc_done_clear", 32'(bus.o_done), 0);
    chk("zc_ready_after", 32'(bus.o_word_ready), 0);
    bus.i_word_valid = 1'b0;
    wq = {16'h4321};
    eq = {16'h1, 16'h2, 16'h3, 16'h4};
    run(4, 1'b0, 4, wq, eq, 1'b0, 2);
    reset = 1'b1;
    @(negedge clk);
    bus.i_word_valid = 1'b0;
    bus.i_val_ready = 1'b0;
    #1;
    chk_idle("abort");
    reset = 1'b0;
    wq = {16'hBEEF};
    eq = {16'h00EF, 16'h00BE};
    run(8, 1'b0, 2, wq, eq, 1'b0, 0);
    wq = {16'h1111};
    eq = {16'h1, 16'h1, 16'h1, 16'h1};
    run(4, 1'b0, 4, wq, eq, 1'b0, 1);
    wq = {16'h5A5A};
    eq = {16'h5A5A};
    run(16, 1'b0, 1, wq, eq, 1'b0, 0);
    for (int t = 0; t < 10; t++) begin
      int n = $urandom_range(0, 20);
      int neff = (n == 0 || n > 16) ? 16 : n;
      bit sgn = 1'($urandom_range(0, 1));
      int cnt = $urandom_range(1, 12);
      int nw = (cnt * neff + 15) / 16;
      wq = {};
      eq = {};
      for (int j = 0; j < nw; j++) wq.push_back(16'($urandom));
      for (int k = 0; k < cnt; k++) eq.push_back(ref_val(wq, neff, sgn, k));
      run(n, sgn, cnt, wq, eq, 1'b1, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
